// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : request opcode encoding, ALU_control constants, issue FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    OP_AND     = 3'd0,
    OP_OR      = 3'd1,
    OP_ADD     = 3'd2,
    OP_SUB     = 3'd3,
    OP_NOR     = 3'd4,
    OP_NAND    = 3'd5,
    OP_SLT     = 3'd6,
    OP_ILLEGAL = 3'd7
  } req_op_e;

  // {A_invert, B_invert/carry-in, operation[1:0]}
  localparam logic [3:0] c_ctrl_and  = 4'b0000;
  localparam logic [3:0] c_ctrl_or   = 4'b0001;
  localparam logic [3:0] c_ctrl_add  = 4'b0010;
  localparam logic [3:0] c_ctrl_sub  = 4'b0110;
  localparam logic [3:0] c_ctrl_nor  = 4'b1100;
  localparam logic [3:0] c_ctrl_nand = 4'b1101;
  localparam logic [3:0] c_ctrl_slt  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
// alu_op_decode : combinational req_op -> ALU_control decode with illegal flag
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic [3:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = c_ctrl_and;
    illegal = 1'b0;
    unique case (req_op_e'(op))
      OP_AND:     ctrl = c_ctrl_and;
      OP_OR:      ctrl = c_ctrl_or;
      OP_ADD:     ctrl = c_ctrl_add;
      OP_SUB:     ctrl = c_ctrl_sub;
      OP_NOR:     ctrl = c_ctrl_nor;
      OP_NAND:    ctrl = c_ctrl_nand;
      OP_SLT:     ctrl = c_ctrl_slt;
      OP_ILLEGAL: illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl : issues one op to a registered ALU and holds its response
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_src1,
  input  logic [31:0]      req_src2,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [3:0]       ALU_control,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_zero,
  output logic             rsp_cout,
  output logic             rsp_overflow,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] w_ctrl;
  logic       w_illegal;
  logic       w_hs;
  logic       w_rsp_fire;

  alu_op_decode u_decode (
    .op      (req_op),
    .ctrl    (w_ctrl),
    .illegal (w_illegal)
  );

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = (r_state == RESP);
  assign w_hs       = req_valid & req_ready;
  assign w_rsp_fire = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = w_illegal ? RESP : EXEC;
      EXEC:    w_next = CAPT;
      CAPT:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ALU operands stay put across illegal requests so the ALU sees no change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_src1    <= '0;
      alu_src2    <= '0;
      ALU_control <= '0;
    end else if (w_hs && !w_illegal) begin
      alu_src1    <= req_src1;
      alu_src2    <= req_src2;
      ALU_control <= w_ctrl;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b0;
    end else if (r_state == CAPT) begin
      rsp_result   <= alu_result;
      rsp_zero     <= alu_zero;
      rsp_cout     <= alu_cout;
      rsp_overflow <= alu_overflow;
      rsp_err      <= 1'b0;
    end else if (w_hs && w_illegal) begin
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          op_count <= '0;
    else if (w_rsp_fire) op_count <= op_count + CNT_W'(1);
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// tb_alu_issue_ctrl : scoreboard bench for alu_issue_ctrl with a registered ALU model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_ctrl;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] res;
    logic        zero;
    logic        cout;
    logic        ovf;
    logic        err;
    int          lat;
    int          hs_cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_src1, req_src2;
  logic [31:0]      alu_src1, alu_src2;
  logic [3:0]       ALU_control;
  logic [31:0]      alu_result;
  logic             alu_zero, alu_cout, alu_overflow;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_zero, rsp_cout, rsp_overflow, rsp_err;
  logic [CNT_W-1:0] op_count;

  int               vectors = 0;
  int               miscompares = 0;
  int               cyc = 0;
  int               hs_count = 0;
  logic             prev_rsp_valid = 1'b0;
  logic [CNT_W-1:0] exp_count = '0;
  exp_t             sb[$];

  alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_src1     (req_src1),
    .req_src2     (req_src2),
    .alu_src1     (alu_src1),
    .alu_src2     (alu_src2),
    .ALU_control  (ALU_control),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_zero     (rsp_zero),
    .rsp_cout     (rsp_cout),
    .rsp_overflow (rsp_overflow),
    .rsp_err      (rsp_err),
    .op_count     (op_count)
  );

  always #5 clk = ~clk;

  // Downstream ALU: bit-sliced style, result registered every cycle.
  function automatic logic [34:0] alu_model(input logic [3:0] ctrl, input logic [31:0] a, b);
    logic [31:0] aa, bb, r;
    logic [32:0] s;
    logic        ov;
    aa = ctrl[3] ? ~a : a;
    bb = ctrl[2] ? ~b : b;
    s  = {1'b0, aa} + {1'b0, bb} + {32'd0, ctrl[2]};
    ov = (aa[31] == bb[31]) && (s[31] != aa[31]);
    case (ctrl[1:0])
      2'b00:   r = aa & bb;
      2'b01:   r = aa | bb;
      2'b10:   r = s[31:0];
      default: r = {31'd0, s[31] ^ ov};
    endcase
    return {r, (r == 32'd0), (ctrl[1] ? s[32] : 1'b0), (ctrl[1] ? ov : 1'b0)};
  endfunction

  always @(posedge clk) begin
    {alu_result, alu_zero, alu_cout, alu_overflow} <= alu_model(ALU_control, alu_src1, alu_src2);
  end

  function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, b);
    exp_t        e;
    logic [32:0] s;
    e     = '0;
    e.op  = op;
    e.lat = 3;
    case (op)
      3'd0: e.res = a & b;
      3'd1: e.res = a | b;
      3'd4: e.res = ~(a | b);
      3'd5: e.res = ~(a & b);
      3'd2: begin
        s      = {1'b0, a} + {1'b0, b};
        e.res  = s[31:0];
        e.cout = s[32];
        e.ovf  = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'd3, 3'd6: begin
        s      = {1'b0, a} + {1'b0, ~b} + 33'd1;
        e.cout = s[32];
        e.ovf  = (a[31] != b[31]) && (s[31] != a[31]);
        e.res  = (op == 3'd3) ? s[31:0] : {31'd0, ($signed(a) < $signed(b))};
      end
      default: begin
        e.err = 1'b1;
        e.lat = 1;
      end
    endcase
    e.zero = !e.err && (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [3:0] exp_ctrl(input logic [2:0] op);
    case (op)
      3'd0:    return 4'b0000;
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0110;
      3'd4:    return 4'b1100;
      3'd5:    return 4'b1101;
      default: return 4'b0111;
    endcase
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_rsp_valid = 1'b0;
    end else begin
      exp_t e;
      cyc++;
      if (rsp_valid && !prev_rsp_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rsp: rsp_valid rose with no request outstanding");
        end else if ((cyc - sb[0].hs_cyc) !== sb[0].lat) begin
          miscompares++;
          $display("FAIL latency op=%0d: got %0d cycles, want %0d", sb[0].op, cyc - sb[0].hs_cyc, sb[0].lat);
        end
      end
      if (rsp_valid && rsp_ready && sb.size() != 0) begin
        e = sb.pop_front();
        vectors++;
        if ({rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err} !== {e.res, e.zero, e.cout, e.ovf, e.err}) begin
          miscompares++;
          $display("FAIL rsp op=%0d: got res=%h z%b c%b v%b e%b, want res=%h z%b c%b v%b e%b",
                   e.op, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err,
                   e.res, e.zero, e.cout, e.ovf, e.err);
        end
      end
      if (req_valid && req_ready) begin
        e        = ref_model(req_op, req_src1, req_src2);
        e.hs_cyc = cyc;
        sb.push_back(e);
        hs_count++;
      end
      prev_rsp_valid = rsp_valid;
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [3:0]  ctrl_before;
    logic [31:0] s1_before, s2_before;
    logic [35:0] snap;
    int          n;
    ctrl_before = ALU_control;
    s1_before   = alu_src1;
    s2_before   = alu_src2;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL req_ready_idle: got %b, want 1", req_ready);
    end
    req_valid = 1'b1; req_op = op; req_src1 = a; req_src2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_src1 = $urandom; req_src2 = $urandom;
    rsp_ready = (hold == 0);
    vectors++;
    if (op == 3'd7) begin
      if ({ALU_control, alu_src1, alu_src2} !== {ctrl_before, s1_before, s2_before}) begin
        miscompares++;
        $display("FAIL alu_hold_illegal: got ctrl=%b src=%h/%h, want ctrl=%b src=%h/%h",
                 ALU_control, alu_src1, alu_src2, ctrl_before, s1_before, s2_before);
      end
    end else if ({ALU_control, alu_src1, alu_src2} !== {exp_ctrl(op), a, b}) begin
      miscompares++;
      $display("FAIL alu_issue op=%0d: got ctrl=%b src=%h/%h, want ctrl=%b src=%h/%h",
               op, ALU_control, alu_src1, alu_src2, exp_ctrl(op), a, b);
    end
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL rsp_timeout op=%0d: rsp_valid=%b after %0d cycles, want 1", op, rsp_valid, n);
    end
    snap = {rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err, rsp_valid, req_ready} !== {snap, 1'b1, 1'b0}) begin
        miscompares++;
        $display("FAIL backpressure_hold: got rsp=%h valid=%b ready=%b, want rsp=%h valid=1 ready=0",
                 {rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err}, rsp_valid, req_ready, snap);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    vectors++;
    if ({op_count, req_ready, rsp_valid} !== {exp_count, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL complete: got count=%0d ready=%b valid=%b, want count=%0d ready=1 valid=0",
               op_count, req_ready, rsp_valid, exp_count);
    end
  endtask

  task automatic check_cleared(input string tag);
    vectors++;
    if ({alu_src1, alu_src2, ALU_control, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err,
         rsp_valid, op_count, req_ready} !== {101'd0, {CNT_W{1'b0}}, 1'b1}) begin
      miscompares++;
      $display("FAIL %s: got src=%h/%h ctrl=%b rsp=%h flags=%b%b%b%b valid=%b count=%0d ready=%b, want all 0 and ready=1",
               tag, alu_src1, alu_src2, ALU_control, rsp_result, rsp_zero, rsp_cout, rsp_overflow,
               rsp_err, rsp_valid, op_count, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_src1 = '0; req_src2 = '0;
    #3;
    check_cleared("reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_count = '0;
  endtask

  task automatic test_legal_ops();
    do_op(3'd2, 32'd7, 32'd5, 0);
    do_op(3'd3, 32'd5, 32'd5, 0);
    do_op(3'd2, 32'h7FFF_FFFF, 32'd1, 0);
    do_op(3'd6, 32'd3, 32'd5, 0);
    do_op(3'd6, 32'd5, 32'd3, 0);
    do_op(3'd6, 32'hFFFF_FFFF, 32'd1, 0);
    for (int op = 0; op < 7; op++) begin
      do_op(3'(op), $urandom, $urandom, 0);
    end
  endtask

  task automatic test_illegal();
    do_op(3'd3, 32'h1234_5678, 32'h0000_1111, 0);
    do_op(3'd7, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(3'd7, 32'd0, 32'd0, 2);
  endtask

  task automatic test_backpressure();
    do_op(3'd2, 32'hDEAD_0000, 32'h0000_BEEF, 5);
    do_op(3'd4, 32'h0F0F_0F0F, 32'h00FF_00FF, 3);
  endtask

  task automatic test_back_to_back();
    int hs0;
    int n;
    hs0 = hs_count;
    req_valid = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req_op = 3'($urandom_range(0, 6)); req_src1 = $urandom; req_src2 = $urandom;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    n = 0;
    while (!req_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    rsp_ready = 1'b0;
    exp_count = exp_count + CNT_W'(4);
    vectors++;
    if ({hs_count - hs0, sb.size(), 28'd0, op_count} !== {32'd4, 32'd0, 28'd0, exp_count}) begin
      miscompares++;
      $display("FAIL back_to_back: got handshakes=%0d pending=%0d count=%0d, want 4, 0, %0d",
               hs_count - hs0, sb.size(), op_count, exp_count);
    end
  endtask

  task automatic test_reset_abort();
    do_op(3'd1, 32'hA5A5_0000, 32'h0000_5A5A, 0);
    req_valid = 1'b1; req_op = 3'd2; req_src1 = 32'd100; req_src2 = 32'd200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_cleared("reset_in_exec");
    sb.delete();
    exp_count = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      vectors++;
      if ({rsp_valid, op_count} !== {1'b0, {CNT_W{1'b0}}}) begin
        miscompares++;
        $display("FAIL abort_no_rsp: got valid=%b count=%0d, want 0 0", rsp_valid, op_count);
      end
    end
    do_op(3'd2, 32'd1, 32'd1, 0);
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 16 && exp_count != '1; i++) begin
      do_op(3'($urandom_range(0, 6)), $urandom, $urandom, 0);
    end
    vectors++;
    if (op_count !== {CNT_W{1'b1}}) begin
      miscompares++;
      $display("FAIL count_all_ones: got %0d, want %0d", op_count, {CNT_W{1'b1}});
    end
    do_op(3'd0, 32'hFFFF_0000, 32'h0F0F_F0F0, 0);
    vectors++;
    if (op_count !== '0) begin
      miscompares++;
      $display("FAIL count_wrap: got %0d, want 0", op_count);
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_legal_ops();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_count_wrap();
    repeat (2) @(posedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending responses, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
